// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
// Packet-atomic 2:1 arbiter in front of the NoC output link. It merges the
// forwarded-flit stream with the CPU-injected stream. Once the first flit of a
// packet wins, that source keeps the link until its tail flit, so packets never
// interleave. Sources alternate at packet boundaries (round robin). A single
// registered output stage drives the link.
//
// Parameters
//   FLIT_W         flit payload width
//   MAX_PKT_FLITS  flits per packet before a forced release (>= 2)
//
// Ports
//   nocclk              NoC clock, all state on posedge
//   rst                 asynchronous active-high reset
//   fwd_flit/_last      forwarded flit and its tail flag
//   fwd_flit_valid      forwarded source valid
//   fwd_flit_ready      forwarded flit accepted when valid & ready
//   cpu_flit/_last      CPU-injected flit and its tail flag
//   cpu_flit_valid      CPU source valid
//   cpu_flit_ready      CPU flit accepted when valid & ready
//   out_flit/_last      registered output flit and tail flag
//   out_flit_valid      output valid
//   out_flit_ready      downstream link ready
//   busy                a packet is currently locked
//   err_pkt_overlength  one-cycle pulse after a watchdog forced release
module noc_output_arbiter #(
    parameter int unsigned FLIT_W        = 32,
    parameter int unsigned MAX_PKT_FLITS = 16
) (
    input  logic              nocclk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] fwd_flit,
    input  logic              fwd_flit_last,
    input  logic              fwd_flit_valid,
    output logic              fwd_flit_ready,
    input  logic [FLIT_W-1:0] cpu_flit,
    input  logic              cpu_flit_last,
    input  logic              cpu_flit_valid,
    output logic              cpu_flit_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_flit_last,
    output logic              out_flit_valid,
    input  logic              out_flit_ready,
    output logic              busy,
    output logic              err_pkt_overlength
);

    localparam int unsigned CNT_W = $clog2(MAX_PKT_FLITS + 1);

    typedef enum logic [1:0] {StIdle, StLockFwd, StLockCpu} state_e;

    state_e            state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;
    logic [FLIT_W-1:0] out_flit_q;
    logic              out_last_q;
    logic              out_valid_q;
    logic              err_q;

    logic              load_en;
    logic              fwd_win;
    logic              cpu_win;
    logic              accept;
    logic              sel_last;
    logic [FLIT_W-1:0] sel_flit;
    logic              forced;
    logic              tail;

    // Source selection and ready generation. Readys depend only on state,
    // valids and the output stage, never on the payload.
    always_comb begin
        fwd_win = 1'b0;
        cpu_win = 1'b0;
        load_en = !out_valid_q || out_flit_ready;
        case (state_q)
            StIdle: begin
                // A lone requester wins regardless of rr_ptr.
                fwd_win = fwd_flit_valid && (!cpu_flit_valid || !rr_ptr_q);
                cpu_win = cpu_flit_valid && (!fwd_flit_valid || rr_ptr_q);
            end
            StLockFwd: fwd_win = 1'b1;
            StLockCpu: cpu_win = 1'b1;
            default: ;
        endcase
        fwd_flit_ready = !rst && fwd_win && load_en;
        cpu_flit_ready = !rst && cpu_win && load_en;
        sel_last = cpu_win ? cpu_flit_last : fwd_flit_last;
        sel_flit = cpu_win ? cpu_flit : fwd_flit;
        accept   = (fwd_flit_ready && fwd_flit_valid) || (cpu_flit_ready && cpu_flit_valid);
        // Watchdog: the MAX_PKT_FLITS-th flit of a packet is turned into its tail.
        forced   = accept && (state_q != StIdle) && !sel_last &&
                   (flit_cnt_q == CNT_W'(MAX_PKT_FLITS - 1));
        tail     = sel_last || forced;
    end

    // Packet lock FSM, round-robin pointer and packet length counter.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        flit_cnt_d = flit_cnt_q;
        if (accept) begin
            if (tail) begin
                state_d    = StIdle;
                rr_ptr_d   = !cpu_win;
                flit_cnt_d = '0;
            end else if (state_q == StIdle) begin
                state_d    = cpu_win ? StLockCpu : StLockFwd;
                flit_cnt_d = CNT_W'(1);
            end else begin
                flit_cnt_d = flit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= 1'b0;
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

    // Output register stage; holds steady while stalled.
    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= forced;
            if (accept) begin
                out_flit_q  <= sel_flit;
                out_last_q  <= tail;
                out_valid_q <= 1'b1;
            end else if (out_flit_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_flit           = out_flit_q;
    assign out_flit_last      = out_last_q;
    assign out_flit_valid     = out_valid_q;
    assign busy               = (state_q != StIdle);
    assign err_pkt_overlength = err_q;

endmodule
